apb_ram_arbiter: RTL and testbench

APB_RAM_ARBITER -- requirements
Module: apb_ram_arbiter

---
 rtl/apb_ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_apb_ram_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_ram_arbiter
// Brief    : Two-requester round-robin arbiter feeding one APB master port,
//            with ACCESS-phase timeout and registered one-shot completions.
// Revision : 1.0 - initial release
// ============================================================================
module apb_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int C_CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic                    prio_q,      prio_d;
    logic                    gnt_q,       gnt_d;
    logic                    pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
    logic [C_CNT_W-1:0]      cnt_q,       cnt_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q,   rsp_err_d;

    logic                    w_any;
    logic                    w_gnt;
    logic [1:0]              w_gnt_oh;
    logic [1:0]              w_req_ready;
    logic                    w_psel;
    logic                    w_penable;
    logic [ADDR_WIDTH-1:0]   w_addr_sel;
    logic [DATA_WIDTH-1:0]   w_wdata_sel;

    // Round-robin only matters on contention; a lone requester always wins.
    assign w_any       = |req_valid;
    assign w_gnt       = (req_valid == 2'b11) ? prio_q : req_valid[1];
    assign w_gnt_oh    = gnt_q ? 2'b10 : 2'b01;
    assign w_addr_sel  = w_gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : req_addr[ADDR_WIDTH-1:0];
    assign w_wdata_sel = w_gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : req_wdata[DATA_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        w_req_ready = 2'b00;
        w_psel      = 1'b0;
        w_penable   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    w_req_ready = w_gnt ? 2'b10 : 2'b01;
                    gnt_d       = w_gnt;
                    prio_d      = ~w_gnt;
                    pwrite_d    = req_write[w_gnt];
                    paddr_d     = w_addr_sel;
                    pwdata_d    = w_wdata_sel;
                    cnt_d       = '0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                w_psel  = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                // PREADY is tested first so a late ready on the last allowed cycle still completes normally.
                if (PREADY) begin
                    rsp_valid_d = w_gnt_oh;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = S_IDLE;
                end else if (cnt_q == C_CNT_LAST) begin
                    rsp_valid_d = w_gnt_oh;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The state register already clears asynchronously; the ready gate keeps
    // a held request from showing acceptance while reset is still asserted.
    assign req_ready = w_req_ready & {2{PRESETn}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = w_psel;
    assign PENABLE   = w_penable;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_ram_arbiter
// Brief    : Vector-table and directed-sequence bench for apb_ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_ram_arbiter;

    localparam logic [7:0]  A0 = 8'h05;
    localparam logic [7:0]  A1 = 8'hFF;
    localparam logic [31:0] W0 = 32'hDEADBEEF;
    localparam logic [31:0] W1 = 32'hCAFEF00D;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    apb_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [1:0]  rv;
        logic [1:0]  rw;
        logic        pr;
        logic        se;
        logic [31:0] prd;
        logic [1:0]  rdy;
        logic        psel;
        logic        pen;
        logic [7:0]  paddr;
        logic        pwr;
        logic [31:0] pwd;
        logic [1:0]  rvo;
        logic        err;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t v(input logic [1:0] rv, input logic [1:0] rw,
                               input logic pr, input logic se, input logic [31:0] prd,
                               input logic [1:0] rdy, input logic psel, input logic pen,
                               input logic [7:0] paddr, input logic pwr, input logic [31:0] pwd,
                               input logic [1:0] rvo, input logic err, input logic [31:0] rdat);
        vec_t r;
        r.rv = rv;   r.rw = rw;     r.pr = pr;   r.se = se;   r.prd = prd;
        r.rdy = rdy; r.psel = psel; r.pen = pen; r.paddr = paddr;
        r.pwr = pwr; r.pwd = pwd;   r.rvo = rvo; r.err = err; r.rdat = rdat;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present a single request in an IDLE cycle and confirm it is accepted.
    task automatic start_req(input logic who, input logic wr);
        req_valid = who ? 2'b10 : 2'b01;
        req_write = who ? {wr, 1'b0} : {1'b0, wr};
        @(negedge PCLK);
        chk("start_ready", 64'(req_ready), 64'(req_valid));
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        req_write = 2'b00;
    endtask

    // Behave as the slave: raise PREADY on ACCESS cycle number ready_at (0-based), or never if negative.
    task automatic run_access(input int ready_at, input logic [1:0] exp_v, input logic exp_err,
                              input logic [31:0] exp_rd, input int exp_acc, input logic [31:0] prd);
        int  acc = 0;
        bit  got = 0;
        PRDATA = prd;
        for (int k = 0; k < 40 && !got; k++) begin
            PREADY = PSEL && PENABLE && (acc == ready_at);
            @(negedge PCLK);
            if (PSEL && PENABLE) acc++;
            if (rsp_valid != 2'b00) begin
                got = 1;
                chk("cpl_valid", 64'(rsp_valid), 64'(exp_v));
                chk("cpl_err",   64'(rsp_err),   64'(exp_err));
                chk("cpl_rdata", 64'(rsp_rdata), 64'(exp_rd));
                chk("cpl_psel",  64'(PSEL),      64'd0);
            end
            @(posedge PCLK); #1;
        end
        PREADY = 1'b0;
        chk("cpl_seen",   64'(got), 64'd1);
        chk("access_cnt", 64'(acc), 64'(exp_acc));
    endtask

    initial begin
        vecs[0]  = v(2'b11, 2'b00, 0, 0, 32'h0,        2'b01, 0, 0, 8'h00, 0, 32'h0, 2'b00, 0, 32'h0);
        vecs[1]  = v(2'b11, 2'b00, 0, 0, 32'h0,        2'b00, 1, 0, A0,    0, W0,    2'b00, 0, 32'h0);
        vecs[2]  = v(2'b11, 2'b00, 1, 0, 32'h11111111, 2'b00, 1, 1, A0,    0, W0,    2'b00, 0, 32'h0);
        vecs[3]  = v(2'b11, 2'b00, 0, 0, 32'h0,        2'b10, 0, 0, A0,    0, W0,    2'b01, 0, 32'h11111111);
        vecs[4]  = v(2'b11, 2'b00, 0, 0, 32'h0,        2'b00, 1, 0, A1,    0, W1,    2'b00, 0, 32'h11111111);
        vecs[5]  = v(2'b11, 2'b00, 1, 0, 32'h22222222, 2'b00, 1, 1, A1,    0, W1,    2'b00, 0, 32'h11111111);
        vecs[6]  = v(2'b11, 2'b00, 0, 0, 32'h0,        2'b01, 0, 0, A1,    0, W1,    2'b10, 0, 32'h22222222);
        vecs[7]  = v(2'b01, 2'b01, 0, 0, 32'h0,        2'b00, 1, 0, A0,    0, W0,    2'b00, 0, 32'h22222222);
        vecs[8]  = v(2'b01, 2'b01, 1, 0, 32'h33333333, 2'b00, 1, 1, A0,    0, W0,    2'b00, 0, 32'h22222222);
        vecs[9]  = v(2'b01, 2'b01, 0, 0, 32'h0,        2'b01, 0, 0, A0,    0, W0,    2'b01, 0, 32'h33333333);
        vecs[10] = v(2'b10, 2'b00, 0, 0, 32'h0,        2'b00, 1, 0, A0,    1, W0,    2'b00, 0, 32'h33333333);
        vecs[11] = v(2'b10, 2'b00, 1, 1, 32'h44444444, 2'b00, 1, 1, A0,    1, W0,    2'b00, 0, 32'h33333333);
        vecs[12] = v(2'b10, 2'b00, 0, 0, 32'h0,        2'b10, 0, 0, A0,    1, W0,    2'b01, 1, 32'h0);
        vecs[13] = v(2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 1, 0, A1,    0, W1,    2'b00, 1, 32'h0);
        vecs[14] = v(2'b00, 2'b00, 1, 0, 32'h55555555, 2'b00, 1, 1, A1,    0, W1,    2'b00, 1, 32'h0);
        vecs[15] = v(2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 0, 0, A1,    0, W1,    2'b10, 0, 32'h55555555);
        vecs[16] = v(2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 0, 0, A1,    0, W1,    2'b00, 0, 32'h55555555);

        PRESETn   = 1'b0;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = {A1, A0};
        req_wdata = {W1, W0};
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_ready",  64'(req_ready), 64'd0);
        chk("rst_psel",   64'({PSEL, PENABLE, PWRITE}), 64'd0);
        chk("rst_paddr",  64'(PADDR), 64'd0);
        chk("rst_pwdata", 64'(PWDATA), 64'd0);
        chk("rst_rsp",    64'({rsp_valid, rsp_err}), 64'd0);
        chk("rst_rdata",  64'(rsp_rdata), 64'd0);

        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            req_valid = vecs[i].rv;
            req_write = vecs[i].rw;
            PREADY    = vecs[i].pr;
            PSLVERR   = vecs[i].se;
            PRDATA    = vecs[i].prd;
            @(negedge PCLK);
            chk($sformatf("v%0d_ready", i),   64'(req_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d_psel", i),    64'(PSEL),      64'(vecs[i].psel));
            chk($sformatf("v%0d_penable", i), 64'(PENABLE),   64'(vecs[i].pen));
            chk($sformatf("v%0d_paddr", i),   64'(PADDR),     64'(vecs[i].paddr));
            chk($sformatf("v%0d_pwrite", i),  64'(PWRITE),    64'(vecs[i].pwr));
            chk($sformatf("v%0d_pwdata", i),  64'(PWDATA),    64'(vecs[i].pwd));
            chk($sformatf("v%0d_rspv", i),    64'(rsp_valid), 64'(vecs[i].rvo));
            chk($sformatf("v%0d_err", i),     64'(rsp_err),   64'(vecs[i].err));
            chk($sformatf("v%0d_rdata", i),   64'(rsp_rdata), 64'(vecs[i].rdat));
            @(posedge PCLK); #1;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;

        // Wait states: ready on the 4th ACCESS cycle.
        start_req(1'b1, 1'b0);
        run_access(3, 2'b10, 1'b0, 32'h12345678, 4, 32'h12345678);

        // Slave never answers: timeout after 16 ACCESS cycles.
        start_req(1'b0, 1'b0);
        run_access(-1, 2'b01, 1'b1, 32'h0, 16, 32'hBBBBBBBB);

        // Ready arrives on the last allowed cycle: normal completion wins.
        start_req(1'b1, 1'b0);
        run_access(15, 2'b10, 1'b0, 32'hA5A5A5A5, 16, 32'hA5A5A5A5);

        // Reset in the middle of ACCESS; prio is 1 at this point.
        start_req(1'b0, 1'b1);
        @(posedge PCLK); #1;
        chk("pre_rst_access", 64'({PSEL, PENABLE}), 64'd3);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("arst_psel",  64'({PSEL, PENABLE}), 64'd0);
        chk("arst_apb",   64'({PWRITE, PADDR, PWDATA}), 64'd0);
        chk("arst_rsp",   64'({rsp_valid, rsp_err}), 64'd0);
        chk("arst_rdata", 64'(rsp_rdata), 64'd0);
        req_valid = 2'b11;
        req_write = 2'b00;
        @(posedge PCLK); #1;
        chk("in_rst_ready", 64'(req_ready), 64'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_grant", 64'(req_ready), 64'd1);
        chk("post_rst_rspv0", 64'(rsp_valid), 64'd0);
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        PREADY    = 1'b1;
        PRDATA    = 32'h0BADF00D;
        @(negedge PCLK);
        chk("post_rst_setup", 64'({PSEL, PENABLE, PADDR}), 64'({2'b10, A0}));
        chk("post_rst_rspv1", 64'(rsp_valid), 64'd0);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("post_rst_access", 64'({PSEL, PENABLE}), 64'd3);
        @(posedge PCLK); #1;
        PREADY = 1'b0;
        @(negedge PCLK);
        chk("post_rst_cpl",   64'(rsp_valid), 64'd1);
        chk("post_rst_rdata", 64'(rsp_rdata), 64'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
